// File: rtl/booth_mult_seq_if.sv
// Request/response bundle for booth_mult_seq.
// The accum request bit exists only when MULT_ACCUM_EN is defined.
interface booth_mult_seq_if #(
   parameter int WIDTH = 32
);
   logic             start;
   logic             is_signed;
`ifdef MULT_ACCUM_EN
   logic             accum;
`endif
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] result_hi;
   logic [WIDTH-1:0] result_lo;

`ifdef MULT_ACCUM_EN
   modport master (
      output start, is_signed, accum, a, b,
      input  busy, done, result_hi, result_lo
   );
   modport slave (
      input  start, is_signed, accum, a, b,
      output busy, done, result_hi, result_lo
   );
`else
   modport master (
      output start, is_signed, a, b,
      input  busy, done, result_hi, result_lo
   );
   modport slave (
      input  start, is_signed, a, b,
      output busy, done, result_hi, result_lo
   );
`endif
endinterface

// File: rtl/booth_mult_seq.sv
// Sequential radix-2 Booth multiplier (MULT/MULTU), one step per clock.
// Optional MADD/MADDU accumulation when MULT_ACCUM_EN is defined.
module booth_mult_seq #(
   parameter int WIDTH = 32,
   parameter int CNT_W = $clog2(WIDTH + 2)
) (
   input  logic           clk,
   input  logic           Reset,
   booth_mult_seq_if.slave bus
);
   localparam int EW = WIDTH + 1;        // extended operand width
   localparam int PW = 2 * WIDTH + 3;    // {acc, multiplier, booth bit}
   localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(WIDTH + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(1);

   typedef enum logic {IDLE, RUN} state_t;

   state_t           state_reg, state_next;
   logic [PW-1:0]    p_reg, p_next;
   logic [EW-1:0]    a_ext_reg, a_ext_next;
   logic [CNT_W-1:0] cnt_reg, cnt_next;
   logic             done_reg, done_next;
   logic [WIDTH-1:0] hi_reg, hi_next;
   logic [WIDTH-1:0] lo_reg, lo_next;
`ifdef MULT_ACCUM_EN
   logic             accum_reg, accum_next;
`endif

   logic             add_op, sub_op;
   logic [EW-1:0]    addend;
   logic [EW-1:0]    upper_sum;
   logic [PW-1:0]    p_step;
   logic [EW-1:0]    a_in_ext, b_in_ext;
   logic [2*WIDTH-1:0] product, final_val;

   assign add_op = (p_reg[1:0] == 2'b01);
   assign sub_op = (p_reg[1:0] == 2'b10);

   // Subtraction is add of the inverted operand with carry-in set.
   genvar gi;
   generate
      for (gi = 0; gi < EW; gi++) begin : g_addend
         assign addend[gi] = (a_ext_reg[gi] ^ sub_op) & (add_op | sub_op);
      end
   endgenerate

   assign upper_sum = p_reg[PW-1 -: EW] + addend + {{(EW-1){1'b0}}, sub_op};
   assign p_step    = {upper_sum[EW-1], upper_sum, p_reg[PW-EW-1:1]};
   assign product   = p_step[2*WIDTH:1];

   assign a_in_ext = {bus.is_signed & bus.a[WIDTH-1], bus.a};
   assign b_in_ext = {bus.is_signed & bus.b[WIDTH-1], bus.b};

`ifdef MULT_ACCUM_EN
   assign final_val = accum_reg ? ({hi_reg, lo_reg} + product) : product;
`else
   assign final_val = product;
`endif

   always_comb begin
      state_next = state_reg;
      p_next     = p_reg;
      a_ext_next = a_ext_reg;
      cnt_next   = cnt_reg;
      done_next  = 1'b0;
      hi_next    = hi_reg;
      lo_next    = lo_reg;
`ifdef MULT_ACCUM_EN
      accum_next = accum_reg;
`endif
      case (state_reg)
         IDLE: begin
            if (bus.start) begin
               a_ext_next = a_in_ext;
               p_next     = {{EW{1'b0}}, b_in_ext, 1'b0};
               cnt_next   = CNT_INIT;
               state_next = RUN;
`ifdef MULT_ACCUM_EN
               accum_next = bus.accum;
`endif
            end
         end
         RUN: begin
            p_next   = p_step;
            cnt_next = cnt_reg - 1'b1;
            if (cnt_reg == CNT_LAST) begin
               hi_next    = final_val[2*WIDTH-1:WIDTH];
               lo_next    = final_val[WIDTH-1:0];
               done_next  = 1'b1;
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!Reset) begin
         state_reg <= IDLE;
         p_reg     <= '0;
         a_ext_reg <= '0;
         cnt_reg   <= '0;
         done_reg  <= 1'b0;
         hi_reg    <= '0;
         lo_reg    <= '0;
`ifdef MULT_ACCUM_EN
         accum_reg <= 1'b0;
`endif
      end else begin
         state_reg <= state_next;
         p_reg     <= p_next;
         a_ext_reg <= a_ext_next;
         cnt_reg   <= cnt_next;
         done_reg  <= done_next;
         hi_reg    <= hi_next;
         lo_reg    <= lo_next;
`ifdef MULT_ACCUM_EN
         accum_reg <= accum_next;
`endif
      end
   end

   assign bus.busy      = (state_reg == RUN);
   assign bus.done      = done_reg;
   assign bus.result_hi = hi_reg;
   assign bus.result_lo = lo_reg;
endmodule

// File: tb/tb_booth_mult_seq.sv
// Scoreboard bench for booth_mult_seq: 32-bit and 8-bit instances, directed vectors.
// Accumulate cases run only when MULT_ACCUM_EN is defined.
module tb_booth_mult_seq;
   logic clk = 1'b0;
   logic Reset;
   int   cyc = 0;
   int   tests_run = 0;
   int   tests_failed = 0;

   typedef struct {
      logic [63:0] prod;
      int          cyc;
   } exp_t;

   exp_t q32[$];
   exp_t q8[$];

   booth_mult_seq_if #(.WIDTH(32)) bus32 ();
   booth_mult_seq_if #(.WIDTH(8))  bus8 ();

   booth_mult_seq #(.WIDTH(32)) dut32 (.clk(clk), .Reset(Reset), .bus(bus32));
   booth_mult_seq #(.WIDTH(8))  dut8  (.clk(clk), .Reset(Reset), .bus(bus8));

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests_run++;
      if (act !== exp) begin
         tests_failed++;
         $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
      end
   endtask

   // Drives a request at the current negedge; caller is positioned on a negedge.
   task automatic issue32(input logic sgn, input logic acc, input logic [31:0] a,
                          input logic [31:0] b, input logic [63:0] exp, input bit push);
      exp_t e;
      bus32.start     = 1'b1;
      bus32.is_signed = sgn;
      bus32.a         = a;
      bus32.b         = b;
`ifdef MULT_ACCUM_EN
      bus32.accum     = acc;
`endif
      if (push) begin
         e.prod = exp;
         e.cyc  = cyc + 34;
         q32.push_back(e);
      end
      $display("[TB] issue32 signed=%0d accum=%0d a=0x%08h b=0x%08h push=%0d", sgn, acc, a, b, push);
      @(negedge clk);
      bus32.start = 1'b0;
   endtask

   task automatic issue8(input logic sgn, input logic [7:0] a, input logic [7:0] b,
                         input logic [15:0] exp);
      exp_t e;
      bus8.start     = 1'b1;
      bus8.is_signed = sgn;
      bus8.a         = a;
      bus8.b         = b;
      e.prod = {48'h0, exp};
      e.cyc  = cyc + 10;
      q8.push_back(e);
      $display("[TB] issue8 signed=%0d a=0x%02h b=0x%02h", sgn, a, b);
      @(negedge clk);
      bus8.start = 1'b0;
   endtask

   task automatic wait_done32(input string name, input int budget);
      int n = 0;
      while (!bus32.done && n < budget) begin
         @(negedge clk);
         n++;
      end
      check(name, {63'h0, bus32.done}, 64'h1);
   endtask

   task automatic wait_done8(input string name, input int budget);
      int n = 0;
      while (!bus8.done && n < budget) begin
         @(negedge clk);
         n++;
      end
      check(name, {63'h0, bus8.done}, 64'h1);
   endtask

   // Monitors: pop expected result on every done pulse.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (bus32.done) begin
            $display("[TB] done32 hi=0x%08h lo=0x%08h cyc=%0d", bus32.result_hi, bus32.result_lo, cyc);
            if (q32.size() == 0) begin
               check("done32_unexpected", 64'h1, 64'h0);
            end else begin
               e = q32.pop_front();
               check("result32", {bus32.result_hi, bus32.result_lo}, e.prod);
               check("latency32", 64'(cyc), 64'(e.cyc));
            end
         end
      end
   end

   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (bus8.done) begin
            $display("[TB] done8 hi=0x%02h lo=0x%02h cyc=%0d", bus8.result_hi, bus8.result_lo, cyc);
            if (q8.size() == 0) begin
               check("done8_unexpected", 64'h1, 64'h0);
            end else begin
               e = q8.pop_front();
               check("result8", {48'h0, bus8.result_hi, bus8.result_lo}, e.prod);
               check("latency8", 64'(cyc), 64'(e.cyc));
            end
         end
      end
   end

   initial begin
      Reset = 1'b0;
      bus32.start = 1'b0; bus32.is_signed = 1'b0; bus32.a = '0; bus32.b = '0;
      bus8.start  = 1'b0; bus8.is_signed  = 1'b0; bus8.a  = '0; bus8.b  = '0;
`ifdef MULT_ACCUM_EN
      bus32.accum = 1'b0;
      bus8.accum  = 1'b0;
`endif
      repeat (3) @(negedge clk);
      check("reset_busy32", {63'h0, bus32.busy}, 64'h0);
      check("reset_done32", {63'h0, bus32.done}, 64'h0);
      check("reset_res32", {bus32.result_hi, bus32.result_lo}, 64'h0);
      check("reset_res8", {48'h0, bus8.result_hi, bus8.result_lo}, 64'h0);
      Reset = 1'b1;
      @(negedge clk);

      // -1 * -1 signed, with cycle-by-cycle busy/done checks
      issue32(1'b1, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'h0000_0000_0000_0001, 1'b1);
      for (int i = 0; i < 33; i++) begin
         if (i > 0) @(negedge clk);
         check("t1_busy_high", {63'h0, bus32.busy}, 64'h1);
         check("t1_done_low", {63'h0, bus32.done}, 64'h0);
         check("t1_hold_res", {bus32.result_hi, bus32.result_lo}, 64'h0);
      end
      @(negedge clk);
      check("t1_busy_end", {63'h0, bus32.busy}, 64'h0);
      check("t1_done_pulse", {63'h0, bus32.done}, 64'h1);
      @(negedge clk);
      check("t1_done_one_cycle", {63'h0, bus32.done}, 64'h0);

      issue32(1'b1, 1'b0, 32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000, 1'b1);
      wait_done32("t2_done", 60);
      @(negedge clk);
      issue32(1'b0, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, 1'b1);
      wait_done32("t3_done", 60);
      @(negedge clk);

      // 7 * -3, ignored mid-run start, then start in the done cycle
      issue32(1'b1, 1'b0, 32'h0000_0007, 32'hFFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFEB, 1'b1);
      repeat (10) @(negedge clk);
      issue32(1'b1, 1'b0, 32'h0000_0002, 32'h0000_0002, 64'h0, 1'b0);
      check("t4_busy_midrun", {63'h0, bus32.busy}, 64'h1);
      wait_done32("t4_done", 60);
      issue32(1'b1, 1'b0, 32'h0000_0002, 32'h0000_0002, 64'h0000_0000_0000_0004, 1'b1);
      wait_done32("t5_done", 60);
      @(negedge clk);

      // 8-bit instance, latency 9
      issue8(1'b0, 8'hFF, 8'h02, 16'h01FE);
      wait_done8("w8_u_done", 20);
      issue8(1'b1, 8'hFF, 8'h02, 16'hFFFE);
      wait_done8("w8_s_done", 20);
      @(negedge clk);

      // Reset at cycle 10 of a run, with start held during reset
      issue32(1'b1, 1'b0, 32'h0000_0005, 32'h0000_0006, 64'h0, 1'b0);
      repeat (9) @(negedge clk);
      check("rst_busy_before", {63'h0, bus32.busy}, 64'h1);
      Reset = 1'b0;
      bus32.start = 1'b1;
      @(negedge clk);
      check("rst_busy", {63'h0, bus32.busy}, 64'h0);
      check("rst_res", {bus32.result_hi, bus32.result_lo}, 64'h0);
      @(negedge clk);
      check("rst_start_ignored", {63'h0, bus32.busy}, 64'h0);
      Reset = 1'b1;
      bus32.start = 1'b0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         check("rst_no_done", {62'h0, bus32.done, bus32.busy}, 64'h0);
      end
      check("rst_res_after", {bus32.result_hi, bus32.result_lo}, 64'h0);

`ifdef MULT_ACCUM_EN
      issue32(1'b1, 1'b0, 32'h0000_0003, 32'h0000_0004, 64'h0000_0000_0000_000C, 1'b1);
      wait_done32("acc1_done", 60);
      @(negedge clk);
      issue32(1'b1, 1'b1, 32'hFFFF_FFFF, 32'h0000_0001, 64'h0000_0000_0000_000B, 1'b1);
      wait_done32("acc2_done", 60);
      @(negedge clk);
      issue32(1'b1, 1'b0, 32'hFFFF_FFFF, 32'h0000_0001, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1);
      wait_done32("acc3_done", 60);
      @(negedge clk);
      issue32(1'b0, 1'b1, 32'h0000_0001, 32'h0000_0001, 64'h0000_0000_0000_0000, 1'b1);
      wait_done32("acc4_done", 60);
      @(negedge clk);
`endif

      repeat (3) @(negedge clk);
      check("sb32_drained", 64'(q32.size()), 64'h0);
      check("sb8_drained", 64'(q8.size()), 64'h0);
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end
endmodule
